booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands. It produces a 2*WIDTH-bit product.
- Sits directly upstream of the 4-bit ripple add/subtract unit (full_adder chain with subtract control). It drives that unit's A, B and subtract-control inputs and consumes its sum and carry-out each iteration.
- The block itself contains no adder. All add/subtract work goes through the external unit via the as_* ports.

Parameters:
- WIDTH, 4, operand width. Must equal the width of the attached add/subtract unit; only 4 is supported with that unit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- mcand  input  WIDTH  signed multiplicand M; captured on an accepted start
- mplier  input  WIDTH  signed multiplier Q; captured on an accepted start
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse, product valid
- product  output  2*WIDTH  signed result; registered and held until the next done
- as_a  output  WIDTH  to adder A; equals the accumulator register Acc
- as_b  output  WIDTH  to adder B; equals the M register
- as_sub  output  1  to adder S_ctrl; 1 when {Q[0],Qm1}=2'b10, else 0
- as_sum  input  WIDTH  from adder S
- as_cout  input  1  from adder C4; unused except for lint, and must be connected

Behaviour:
- Reset (async, immediate):
  - state=IDLE; Acc, Q, M, Qm1, count and product are 0; done=0; ready=1.
- States:
  - IDLE: ready=1. When start=1, load Acc=0, Q=mplier, M=mcand, Qm1=0, count=WIDTH, then go to RUN.
  - RUN: one Booth iteration per clock, then count is decremented. When count reaches 1, the iteration is performed and the state goes to DONE.
  - DONE: done=1 for exactly this cycle; ready=0; start is ignored. The state returns to IDLE on the next edge.
- Iteration, on {Q[0],Qm1}:
  - 01: R=as_sum (as_sub=0, add).
  - 10: R=as_sum (as_sub=1, subtract).
  - 00 or 11: R=Acc.
  - Then arithmetic shift right of {R,Q,Qm1}: Acc={sgn,R[WIDTH-1:1]}, Q={R[0],Q[WIDTH-1:1]}, Qm1=Q[0].
- Sign bit sgn:
  - For add/sub, ovf = (Acc[MSB]==Bx[MSB]) && (as_sum[MSB]!=Acc[MSB]), where Bx=M^{WIDTH{as_sub}}. Then sgn = as_sum[MSB]^ovf. This is the true sign; it covers M=-8 with a subtract.
  - For no-op, sgn=Acc[MSB].
- Product timing:
  - On the RUN->DONE edge, product <= {Acc_next,Q_next}.
  - done rises WIDTH+1 clocks after the accepted start edge.
  - Throughput is one multiply per WIDTH+2 cycles.
- Boundary conditions:
  - start while RUN or DONE: ignored; no state change, and operands are not recaptured.
  - start held high continuously: a new operation is accepted on every IDLE cycle.
  - Operands changing after acceptance: no effect.
  - Reset mid-RUN: immediate return to IDLE with all registers 0. The previous product is lost (reads 0) and no done pulse is produced.
  - as_* outputs are driven from registers in every state. Values outside RUN are don't-care for the adder but deterministic: 0 after reset.

Optional Feature:
- Macro: BOOTH_ZERO_BYPASS_EN.
- Defined: if an accepted start has mcand==0 or mplier==0, go straight IDLE->DONE with product<=0. done rises 1 clock after start; RUN is skipped and the adder is never exercised.
- Undefined: every operation takes the full WIDTH RUN cycles; a zero operand still yields product 0 after WIDTH+1 clocks.

Test Plan:
- mcand=3, mplier=5, start one cycle -> done exactly 5 clocks later, product=8'h0F, ready back to 1 the next cycle.
- mcand=-3 (4'hD), mplier=5 -> product=8'hF1 (-15). mcand=7, mplier=-8 (4'h8) -> product=8'hC8 (-56).
- mcand=-8, mplier=-8 -> product=8'h40 (+64). Exercises the subtract-overflow sign correction; a wrong sgn yields 8'hC0.
- Start 3x5, then pulse start with 2x2 during RUN cycle 2 -> only one done, product=8'h0F; the second request is not queued.
- Start 3x5, assert rst asynchronously mid-RUN (between edges) -> state=IDLE, product=0 and ready=1 immediately; no done. A subsequent 2x-2 gives 8'hFC.
- mcand=0, mplier=6 -> product=0. done arrives 1 clock after start with BOOTH_ZERO_BYPASS_EN defined, 5 clocks after start without it; run both builds.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier driving an external add/subtract unit.
// Optional BOOTH_ZERO_BYPASS_EN: a zero operand skips RUN and finishes in one cycle.
module booth_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   as_a_o,
  output logic [WIDTH-1:0]   as_b_o,
  output logic               as_sub_o,
  input  logic [WIDTH-1:0]   as_sum_i,
  input  logic               as_cout_i
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               op, sub, ovf, sgn;
  logic [WIDTH-1:0]   bx, r, acc_sh, q_sh;
  logic               unused_cout;

  assign unused_cout = as_cout_i;

  // One Booth step: optional add/sub through the external unit, then arithmetic shift.
  // The sign bit is corrected for overflow so M = most-negative still shifts correctly.
  always_comb begin
    op     = q_q[0] ^ qm1_q;
    sub    = q_q[0] & ~qm1_q;
    bx     = m_q ^ {WIDTH{sub}};
    ovf    = (acc_q[WIDTH-1] == bx[WIDTH-1]) && (as_sum_i[WIDTH-1] != acc_q[WIDTH-1]);
    r      = op ? as_sum_i : acc_q;
    sgn    = op ? (as_sum_i[WIDTH-1] ^ ovf) : acc_q[WIDTH-1];
    acc_sh = {sgn, r[WIDTH-1:1]};
    q_sh   = {r[0], q_q[WIDTH-1:1]};
  end

  assign as_a_o    = acc_q;
  assign as_b_o    = m_q;
  assign as_sub_o  = sub;
  assign ready_o   = (state_q == IDLE);
  assign done_o    = (state_q == DONE);
  assign product_o = prod_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          q_d     = mplier_i;
          m_d     = mcand_i;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
`ifdef BOOTH_ZERO_BYPASS_EN
          if (mcand_i == '0 || mplier_i == '0) begin
            prod_d  = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          prod_d  = {acc_sh, q_sh};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
endmodule
